// File: rtl/clock_div_bank_if.sv
// Signal bundle for clock_div_bank: per-channel divide requests in, per-channel
// divided clocks, enables and staged resets out.
interface clock_div_bank_if #(
  parameter int NCH  = 2,
  parameter int SIZE = 8
);
  // No valid/ready here: div_load and sync are single-cycle strobes sampled on
  // every posedge; outputs are registered and valid on every cycle.
  logic [NCH*SIZE-1:0] div;
  logic [NCH-1:0]      div_load;
  logic                sync;
  logic [NCH-1:0]      tick;
  logic [NCH-1:0]      div_out;
  logic [NCH-1:0]      rst_out;
  logic [NCH-1:0]      pending;

  modport master (
    output div, div_load, sync,
    input  tick, div_out, rst_out, pending
  );

  modport slave (
    input  div, div_load, sync,
    output tick, div_out, rst_out, pending
  );
endinterface

// File: rtl/clock_div_bank.sv
// Bank of NCH independent programmable clock dividers with shadowed divide
// values, period-boundary updates, a shared phase sync and staged resets.
module clock_div_bank #(
  parameter int NCH         = 2,
  parameter int SIZE        = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int RST_TICKS   = 3
) (
  input  logic              clk,
  input  logic              reset,
  clock_div_bank_if.slave   bus
);

  localparam logic [SIZE-1:0] DEF_DIV  = SIZE'(DEFAULT_DIV);
  localparam logic [2:0]      RST_INIT = 3'(RST_TICKS);

  logic [SIZE-1:0] shadow_q [NCH];
  logic [SIZE-1:0] shadow_d [NCH];
  logic [SIZE-1:0] active_q [NCH];
  logic [SIZE-1:0] active_d [NCH];
  logic [SIZE-1:0] cnt_q    [NCH];
  logic [SIZE-1:0] cnt_d    [NCH];
  logic [2:0]      rdly_q   [NCH];
  logic [2:0]      rdly_d   [NCH];
  logic [SIZE-1:0] half     [NCH];
  logic            bnd      [NCH];

  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] div_out_q, div_out_d;
  logic [NCH-1:0] rst_out_q, rst_out_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic           run_q, run_d;

  // run_q holds every counter at phase 0 for the first cycle after reset, so
  // the registered outputs start their first period one cycle after release.
  always_comb begin
    run_d     = 1'b1;
    tick_d    = '0;
    div_out_d = '0;
    rst_out_d = '0;
    pending_d = '0;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = bus.div_load[i] ? bus.div[i*SIZE +: SIZE] : shadow_q[i];
      bnd[i]      = tick_q[i] || (active_q[i] == '0);
      active_d[i] = (bus.sync || bnd[i]) ? shadow_d[i] : active_q[i];

      if (bus.sync || !run_q || bnd[i] || (active_d[i] < SIZE'(2)))
        cnt_d[i] = '0;
      else
        cnt_d[i] = cnt_q[i] + SIZE'(1);

      // ceil(N/2) as floor(N/2) + lsb never exceeds SIZE bits
      half[i] = (active_d[i] >> 1) + {{(SIZE-1){1'b0}}, active_d[i][0]};

      tick_d[i]    = (active_d[i] == SIZE'(1)) ||
                     ((active_d[i] > SIZE'(1)) && (cnt_d[i] == active_d[i] - SIZE'(1)));
      div_out_d[i] = (active_d[i] != '0) && (cnt_d[i] < half[i]);
      pending_d[i] = (shadow_d[i] != active_d[i]);

      rdly_d[i]    = (tick_q[i] && (rdly_q[i] != 3'd0)) ? rdly_q[i] - 3'd1 : rdly_q[i];
      rst_out_d[i] = (rdly_d[i] != 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= 1'b0;
      tick_q    <= '0;
      div_out_q <= '0;
      rst_out_q <= '1;
      pending_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= DEF_DIV;
        active_q[i] <= DEF_DIV;
        cnt_q[i]    <= '0;
        rdly_q[i]   <= RST_INIT;
      end
    end else begin
      run_q     <= run_d;
      tick_q    <= tick_d;
      div_out_q <= div_out_d;
      rst_out_q <= rst_out_d;
      pending_q <= pending_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        cnt_q[i]    <= cnt_d[i];
        rdly_q[i]   <= rdly_d[i];
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.div_out = div_out_q;
  assign bus.rst_out = rst_out_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_clock_div_bank.sv
// Self-checking bench for clock_div_bank: time-based reference model checked
// every cycle, directed ratio/sync/reset scenarios, then randomized traffic.
module tb_clock_div_bank;
  localparam int NCH  = 2;
  localparam int SIZE = 8;
  localparam int DEF  = 2;
  localparam int RT   = 3;

  logic clk;
  logic reset;
  clock_div_bank_if #(.NCH(NCH), .SIZE(SIZE)) bus ();

  clock_div_bank #(.NCH(NCH), .SIZE(SIZE), .DEFAULT_DIV(DEF), .RST_TICKS(RT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel's period position is (cycle - start of period). A period
  // restarts after a tick, every cycle while disabled, or on sync; counting
  // begins one cycle after reset release.
  int m_sh    [NCH];
  int m_act   [NCH];
  int m_start [NCH];
  int m_ticks [NCH];
  int mcyc = 0;
  bit chk_en = 1'b0;
  logic [NCH-1:0] e_tick, e_div, e_rst, e_pend;

  always @(posedge clk) begin
    int n, pos;
    bit restart;
    mcyc++;
    if (reset) begin
      chk_en = 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
        m_sh[ch] = DEF; m_act[ch] = DEF; m_start[ch] = mcyc + 1; m_ticks[ch] = 0;
        e_tick[ch] = 1'b0; e_div[ch] = 1'b0; e_rst[ch] = 1'b1; e_pend[ch] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        restart = e_tick[ch] || (m_act[ch] == 0) || bus.sync;
        if (e_tick[ch] && m_ticks[ch] < RT) m_ticks[ch]++;
        if (bus.div_load[ch]) m_sh[ch] = int'(bus.div[ch*SIZE +: SIZE]);
        if (restart) begin
          m_act[ch]   = m_sh[ch];
          m_start[ch] = mcyc;
        end
        n   = m_act[ch];
        pos = mcyc - m_start[ch];
        e_tick[ch] = (n == 1) || (n >= 2 && pos == n - 1);
        e_div[ch]  = (n > 0) && (2 * pos < n);
        e_pend[ch] = (m_sh[ch] != m_act[ch]);
        e_rst[ch]  = (m_ticks[ch] < RT);
      end
    end
  end

  // single compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("tick",    32'(bus.tick),    32'(e_tick));
      check("div_out", 32'(bus.div_out), 32'(e_div));
      check("rst_out", 32'(bus.rst_out), 32'(e_rst));
      check("pending", 32'(bus.pending), 32'(e_pend));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    bus.div_load = '0;
    bus.sync     = 1'b0;
  endtask

  task automatic load(input int ch, input int val);
    bus.div[ch*SIZE +: SIZE] = SIZE'(val);
    bus.div_load[ch] = 1'b1;
  endtask

  // advance until channel ch shows a tick; n = cycles advanced
  task automatic tick_wait(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick[ch] && n < 600);
    if (!bus.tick[ch]) check("tick_wait_timeout", 32'(bus.tick[ch]), 32'd1);
  endtask

  // called in a tick cycle: length and high count of the following period
  task automatic measure(input int ch, output int len, output int high);
    len = 0; high = 0;
    do begin
      step();
      len++;
      high += int'(bus.div_out[ch]);
    end while (!bus.tick[ch] && len < 600);
    if (!bus.tick[ch]) check("measure_timeout", 32'(bus.tick[ch]), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] tv, dv, rv;
    int n, n2, len, high, k0, k1;
    logic pend_mid, and_t, and_d, or_t, or_d, and_r;

    reset = 1'b1; bus.div = '0; bus.div_load = '0; bus.sync = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // release sequence at the default ratio of 2
    for (int k = 0; k < 9; k++) begin
      tv[k] = bus.tick[0]; dv[k] = bus.div_out[0]; rv[k] = bus.rst_out[0];
      step();
    end
    check("rel_tick_seq", 32'(tv), 32'h154);
    check("rel_div_seq",  32'(dv), 32'h0AA);
    check("rel_rst_seq",  32'(rv), 32'h07F);

    // load 4 in the tick cycle of an N=2 channel
    tick_wait(0, n);
    load(0, 4);
    measure(0, len, high);
    check("bypass_len", 32'(len), 32'd4);
    check("bypass_pending", 32'(bus.pending[0]), 32'd0);

    // odd ratio 5
    load(0, 5);
    measure(0, len, high);
    check("odd5_len",  32'(len),  32'd5);
    check("odd5_high", 32'(high), 32'd3);

    // mid-period change 6 -> 3 at cnt=2
    load(0, 6);
    measure(0, len, high);
    check("n6_len", 32'(len), 32'd6);
    step(); step(); step();
    load(0, 3);
    step();
    pend_mid = bus.pending[0];
    tick_wait(0, n2);
    check("mid_pending", 32'(pend_mid), 32'd1);
    check("mid_finish",  32'(n2 + 1),   32'd3);
    measure(0, len, high);
    check("mid_new_len", 32'(len), 32'd3);
    check("mid_pending_clear", 32'(bus.pending[0]), 32'd0);

    // N=1 on channel 0
    load(0, 1);
    and_t = 1'b1; and_d = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      and_t &= bus.tick[0]; and_d &= bus.div_out[0];
    end
    check("n1_tick", 32'(and_t), 32'd1);
    check("n1_div",  32'(and_d), 32'd1);

    // N=255
    load(0, 255);
    measure(0, len, high);
    check("n255_len",  32'(len),  32'd255);
    check("n255_high", 32'(high), 32'd128);

    // sync: set ch0=4, ch1=6, then resync mid-count
    load(0, 4); load(1, 6); bus.sync = 1'b1;
    step(); step(); step();
    bus.sync = 1'b1;
    k0 = -1; k1 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.tick[0] && k0 < 0) k0 = k;
      if (bus.tick[1] && k1 < 0) k1 = k;
    end
    check("sync_first_tick_ch0", 32'(k0 - 1), 32'd3);
    check("sync_first_tick_ch1", 32'(k1 - 1), 32'd5);

    // sync together with reset
    bus.sync = 1'b1; bus.div_load = '1; bus.div = 16'h0907; reset = 1'b1;
    step();
    reset = 1'b0;
    check("sr_tick",    32'(bus.tick),    32'd0);
    check("sr_div",     32'(bus.div_out), 32'd0);
    check("sr_rst",     32'(bus.rst_out), 32'd3);
    check("sr_pending", 32'(bus.pending), 32'd0);

    // disabled channel keeps its staged reset
    tick_wait(1, n);
    load(1, 0);
    or_t = 1'b0; or_d = 1'b0; and_r = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      or_t |= bus.tick[1]; or_d |= bus.div_out[1]; and_r &= bus.rst_out[1];
    end
    check("n0_tick", 32'(or_t),  32'd0);
    check("n0_div",  32'(or_d),  32'd0);
    check("n0_rst",  32'(and_r), 32'd1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      bus.sync = ($urandom_range(0, 39) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        bus.div_load[ch] = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 9))
          0:       bus.div[ch*SIZE +: SIZE] = '0;
          1:       bus.div[ch*SIZE +: SIZE] = SIZE'(1);
          2:       bus.div[ch*SIZE +: SIZE] = ($urandom_range(0, 9) == 0) ? SIZE'(255)
                                                                         : SIZE'($urandom_range(2, 40));
          default: bus.div[ch*SIZE +: SIZE] = SIZE'($urandom_range(2, 12));
        endcase
      end
      @(negedge clk);
    end
    reset = 1'b0; bus.div_load = '0; bus.sync = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_div_bank.md
CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

Interface
REQ-001 Parameter NCH, default 2: number of independent divider channels (1..8).
REQ-002 Parameter SIZE, default 8: divide-value width per channel (2..16).
REQ-003 Parameter DEFAULT_DIV, default 2: active and shadow divide value of every channel after reset.
REQ-004 Parameter RST_TICKS, default 3: per-channel reset-release delay in channel ticks (1..7).
REQ-005 clk  input  1: single clock; all state on posedge clk.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 div  input  NCH*SIZE: requested divide value per channel; channel i in bits [i*SIZE +: SIZE].
REQ-008 div_load  input  NCH: per-channel strobe; writes div slice i into shadow register i.
REQ-009 sync  input  1: one-cycle strobe; realigns all channel counters to phase 0.
REQ-010 tick  output  NCH: one-cycle enable pulse per channel period.
REQ-011 div_out  output  NCH: registered divided square wave per channel.
REQ-012 rst_out  output  NCH: per-channel active-high staged reset.
REQ-013 pending  output  NCH: high while shadow i differs from active i.

Function
REQ-014 Each channel SHALL hold shadow (SIZE), active (SIZE), counter cnt (SIZE) and reset-delay count (3 bits).
REQ-015 N = active value; N=0 means channel disabled: cnt held 0, tick=0, div_out=0.
REQ-016 N=1: tick=1 every cycle, div_out=1 constantly, cnt held 0.
REQ-017 N>=2: cnt counts 0..N-1 and wraps to 0; tick=1 exactly in cycles where cnt==N-1.
REQ-018 N>=2: div_out SHALL be a flop output equal to 1 in cycles where cnt < ceil(N/2), else 0; odd N gives the extra high cycle.
REQ-019 div_load[i] SHALL write shadow i on that edge; div_load has no other immediate effect.
REQ-020 Active SHALL be updated from shadow only at a period boundary: an edge where tick[i]=1, or at any edge while active==0.
REQ-021 A div_load in a boundary cycle SHALL bypass: the new div value becomes active at that edge.
REQ-022 The first period after an update SHALL start at cnt=0 with the new N; no truncated or stretched period.
REQ-023 pending[i] SHALL be registered and equal (shadow != active) after each edge.
REQ-024 sync=1 SHALL, at that edge, load active from shadow (or from div when div_load is also high) and force cnt to 0 on all channels; sync wins over boundary and over counting.
REQ-025 Channel counters SHALL be fully independent except for the shared sync.
REQ-026 All arithmetic SHALL be unsigned SIZE-bit; ceil(N/2) computed without overflow at N=2^SIZE-1.

Reset
REQ-027 reset=1 SHALL on the next edge set shadow=active=DEFAULT_DIV, cnt=0, tick=0, div_out=0, pending=0, rst_out=all ones, reset-delay=RST_TICKS.
REQ-028 reset SHALL override sync, div_load and counting in the same cycle.
REQ-029 After reset, each tick[i] pulse SHALL decrement delay i; rst_out[i] SHALL drop the cycle after the RST_TICKS-th tick and stay 0 until next reset.
REQ-030 A disabled channel (N=0) SHALL keep rst_out=1 indefinitely.
REQ-031 Reset asserted mid-period SHALL abort the period immediately with no trailing tick.

Verification
REQ-032 Defaults (NCH=2, SIZE=8): release reset -> tick on cycles 2,4,6,...; div_out 1,0,1,0 from cycle 1; rst_out drops after 3rd tick (cycle 7).
REQ-033 Odd ratio: load 5 during channel 0 idle-at-boundary -> period 5, div_out high 3 cycles, low 2; tick on cnt==4 only.
REQ-034 Mid-period change: N=6 active, load 3 at cnt=2 -> pending=1, current period completes 6 cycles, next period is 3; pending clears at that boundary.
REQ-035 Simultaneous load+boundary: div_load with 4 in the tick cycle of an N=2 channel -> next period length 4, pending stays 0.
REQ-036 sync: channels at N=4 and N=6 mid-count, pulse sync -> both cnt=0 next cycle, first ticks 3 and 5 cycles later; sync with reset -> reset values only.
REQ-037 Edge ratios: N=0 -> tick=div_out=0, rst_out stays 1; N=1 -> tick and div_out constant 1; N=255 -> high 128, low 127 cycles.
